// File: rtl/galois_lfsr_keystream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : galois_lfsr_keystream
//  Description : Parametrised LFSR keystream generator. Runs either a Galois
//                or a Fibonacci LFSR and packs OUT_W successive output bits
//                (first bit in the MSB) into words. The words are delivered
//                on a valid/ready handshake. An all-zero state is never
//                entered: the register is forced to all ones and a sticky
//                lockup flag is raised instead.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      clock, all logic on rising edge
//    rst_n      in   1      synchronous active-low reset
//    en         in   1      run enable, words are generated while high
//    ld         in   1      load seed (priority over the FSM)
//    mode       in   1      0 = Galois, 1 = Fibonacci (sampled every shift)
//    taps       in   N      feedback polynomial mask
//    seed       in   N      value loaded on ld
//    out_data   out  OUT_W  keystream word, first-generated bit in MSB
//    out_valid  out  1      out_data valid
//    out_ready  in   1      consumer accepts when out_valid && out_ready
//    state_o    out  N      current LFSR state
//    busy       out  1      high while a word is being filled
//    lockup     out  1      sticky: zero state detected or zero seed loaded
// ============================================================================
module galois_lfsr_keystream #(
    parameter int N     = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic             mode,
    input  logic [N-1:0]     taps,
    input  logic [N-1:0]     seed,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     state_o,
    output logic             busy,
    output logic             lockup
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Registered state
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_lfsr;
    logic [OUT_W-1:0] r_shreg;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_lockup;

    // Next-state values
    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [N-1:0]     w_lfsr_nxt;
    logic [OUT_W-1:0] w_shreg_nxt;
    logic [OUT_W-1:0] w_out_data_nxt;
    logic             w_out_valid_nxt;
    logic             w_lockup_nxt;

    // Shift datapath
    logic             w_b;
    logic [N-1:0]     w_galois;
    logic [N-1:0]     w_fib;
    logic [N-1:0]     w_shift_raw;
    logic             w_shift_zero;
    logic [N-1:0]     w_shift_val;
    logic [OUT_W-1:0] w_word;
    logic             w_last_bit;

    assign w_b          = r_lfsr[N-1];
    assign w_galois     = {r_lfsr[N-2:0], 1'b0} ^ (taps & {N{w_b}});
    assign w_fib        = {r_lfsr[N-2:0], ^(r_lfsr & taps)};
    assign w_shift_raw  = mode ? w_fib : w_galois;
    // A zero state would lock the LFSR forever; substitute all ones.
    assign w_shift_zero = (w_shift_raw == '0);
    assign w_shift_val  = w_shift_zero ? {N{1'b1}} : w_shift_raw;
    assign w_last_bit   = (r_cnt == CW'(OUT_W - 1));

    // Current word with this cycle's bit dropped into position OUT_W-1-cnt,
    // so the completed word can be registered in the same cycle as its last bit.
    always_comb begin
        w_word = r_shreg;
        for (int i = 0; i < OUT_W; i++) begin
            if (CW'(OUT_W - 1 - i) == r_cnt) begin
                w_word[i] = w_b;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lfsr_nxt      = r_lfsr;
        w_shreg_nxt     = r_shreg;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_lockup_nxt    = r_lockup;

        if (ld) begin
            // Load discards any partial or pending word.
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_lockup_nxt    = (seed == '0);
            w_lfsr_nxt      = (seed == '0) ? {N{1'b1}} : seed;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        w_state_nxt = S_FILL;
                        w_cnt_nxt   = '0;
                    end
                end
                S_FILL: begin
                    // en is not consulted here: a started word always completes.
                    w_lfsr_nxt  = w_shift_val;
                    w_shreg_nxt = w_word;
                    if (w_shift_zero) begin
                        w_lockup_nxt = 1'b1;
                    end
                    if (w_last_bit) begin
                        w_out_data_nxt  = w_word;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = S_VALID;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = en ? S_FILL : S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lfsr      <= {N{1'b1}};
            r_shreg     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_shreg     <= w_shreg_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_lockup    <= w_lockup_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign state_o   = r_lfsr;
    assign busy      = (r_state == S_FILL);
    assign lockup    = r_lockup;

endmodule
`default_nettype wire

// File: tb/tb_galois_lfsr_keystream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_galois_lfsr_keystream
//  Description : Self-checking bench for galois_lfsr_keystream. A reference
//                LFSR model predicts each word and the state after it; the
//                predictions are queued and compared at every handshake.
//                A second small instance (N=4, OUT_W=1) checks the period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_galois_lfsr_keystream;

    localparam int N  = 32;
    localparam int OW = 8;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, ld, mode, out_ready;
    logic [N-1:0]  taps, seed;
    logic [OW-1:0] out_data;
    logic          out_valid, busy, lockup;
    logic [N-1:0]  state_o;

    logic          ld2, en2;
    logic [3:0]    seed2, state2;
    logic [0:0]    data2;
    logic          valid2, busy2, lock2;

    galois_lfsr_keystream #(.N(N), .OUT_W(OW)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .mode(mode),
        .taps(taps), .seed(seed), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .state_o(state_o), .busy(busy), .lockup(lockup)
    );

    galois_lfsr_keystream #(.N(4), .OUT_W(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en2), .ld(ld2), .mode(1'b0),
        .taps(4'b0011), .seed(seed2), .out_data(data2), .out_valid(valid2),
        .out_ready(1'b1), .state_o(state2), .busy(busy2), .lockup(lock2)
    );

    typedef struct packed {
        logic [OW-1:0] word;
        logic [N-1:0]  st;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            rx_cnt = 0;
    logic [OW-1:0] last_rx = '0;

    // reference model state
    logic [N-1:0]  m_lfsr;
    logic          m_lock;
    logic          m_mode;
    logic [N-1:0]  m_taps;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] m_step(input logic [N-1:0] s, output logic zero);
        logic [N-1:0] nx;
        logic         fb;
        if (!m_mode) begin
            nx = s << 1;
            if (s[N-1]) nx = nx ^ m_taps;
        end else begin
            fb = 1'b0;
            for (int i = 0; i < N; i++) if (m_taps[i]) fb = fb ^ s[i];
            nx = {s[N-2:0], fb};
        end
        zero = (nx == '0);
        if (zero) nx = ONES;
        return nx;
    endfunction

    task automatic push_words(input int k);
        logic [OW-1:0] w;
        logic          z;
        for (int n = 0; n < k; n++) begin
            w = '0;
            for (int b = 0; b < OW; b++) begin
                w      = {w[OW-2:0], m_lfsr[N-1]};
                m_lfsr = m_step(m_lfsr, z);
                if (z) m_lock = 1'b1;
            end
            sb.push_back({w, m_lfsr});
        end
    endtask

    // Scoreboard consumer: a word is taken at the posedge following a
    // negedge that sees valid && ready with no load or reset pending.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !ld && out_valid && out_ready) begin
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_data", out_data, e.word);
                chk("rx_state", state_o, e.st);
            end
            last_rx = out_data;
            rx_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ld(input logic [N-1:0] s);
        seed = s;
        ld   = 1'b1;
        tick();
        ld   = 1'b0;
        m_lfsr = (s == '0) ? ONES : s;
        m_lock = (s == '0);
    endtask

    task automatic wait_rx(input int target);
        int c = 0;
        while (rx_cnt < target && c < 300) begin
            tick();
            c++;
        end
        chk("rx_count", (rx_cnt >= target), 1);
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
        chk("valid_rise", out_valid, 1);
    endtask

    task automatic drain();
        int c = 0;
        en = 1'b0;
        while ((busy || out_valid) && c < 50) begin
            tick();
            c++;
        end
        chk("drain_idle", {busy, out_valid}, 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cyc, r0, shifts, c;
        logic zero_seen;
        logic [3:0] prev;

        rst_n = 1'b0; en = 1'b0; ld = 1'b0; mode = 1'b0; out_ready = 1'b1;
        taps  = 32'h04C11DB7; seed = '0;
        ld2   = 1'b0; en2 = 1'b0; seed2 = '0;
        tick(3);

        // reset values
        chk("rst_state", state_o, ONES);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_state4", state2, 4'hF);

        // Galois from reset: latency and first word
        m_mode = 1'b0; m_taps = taps; m_lfsr = ONES; m_lock = 1'b0;
        push_words(6);
        rst_n = 1'b1; en = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, 9);
        chk("first_word", out_data, 8'hFC);
        wait_rx(4);
        drain();

        // random taps / seeds in both modes
        for (int p = 0; p < 4; p++) begin
            mode = p[0];
            taps = $urandom;
            m_mode = mode; m_taps = taps;
            do_ld($urandom | 32'h1);
            push_words(6);
            r0 = rx_cnt;
            en = 1'b1;
            wait_rx(r0 + 4);
            drain();
        end

        // backpressure: word and state frozen while ready is low
        mode = 1'b0; taps = 32'h04C11DB7; m_mode = 1'b0; m_taps = taps;
        do_ld(32'h12345678);
        push_words(3);
        out_ready = 1'b0; en = 1'b1;
        wait_valid();
        en = 1'b0;
        tick(20);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, sb[0].word);
        chk("hold_state", state_o, sb[0].st);
        r0 = rx_cnt;
        out_ready = 1'b1;
        tick();
        chk("accept_clear", out_valid, 0);
        tick(3);
        chk("accept_once", rx_cnt, r0 + 1);
        chk("accept_idle", busy, 0);
        sb.delete();

        // zero seed and recovery
        do_ld('0);
        chk("ld0_state", state_o, ONES);
        chk("ld0_lockup", lockup, 1);
        do_ld(32'h5);
        chk("ld5_state", state_o, 32'h5);
        chk("ld5_lockup", lockup, 0);

        // lockup from a shift: taps=0, MSB-only seed
        taps = '0; m_taps = '0;
        do_ld(32'h80000000);
        push_words(3);
        r0 = rx_cnt;
        en = 1'b1;
        tick(2);
        chk("lk_state", state_o, ONES);
        chk("lk_flag", lockup, 1);
        wait_rx(r0 + 1);
        chk("lk_bit", last_rx[OW-1], 1);
        drain();
        chk("lk_sticky", lockup, 1);

        // load in the middle of a word
        taps = 32'h04C11DB7; m_taps = taps;
        do_ld(32'hDEADBEEF);
        r0 = rx_cnt;
        en = 1'b1;
        tick(4);
        chk("mid_busy", busy, 1);
        en = 1'b0;
        do_ld(32'h0BADF00D);
        chk("mid_valid", out_valid, 0);
        chk("mid_idle", busy, 0);
        chk("mid_state", state_o, 32'h0BADF00D);
        chk("mid_lockup", lockup, 0);
        tick(12);
        chk("mid_no_word", rx_cnt, r0);

        // reset while a word is pending
        do_ld(32'h13579BDF);
        push_words(2);
        out_ready = 1'b0; en = 1'b1;
        wait_valid();
        rst_n = 1'b0;
        tick();
        chk("rv_valid", out_valid, 0);
        chk("rv_busy", busy, 0);
        chk("rv_data", out_data, 0);
        chk("rv_state", state_o, ONES);
        rst_n = 1'b1; en = 1'b0; out_ready = 1'b1;
        r0 = rx_cnt;
        tick(5);
        chk("rv_no_word", rx_cnt, r0);
        sb.delete();

        // N=4 maximal-length period
        seed2 = 4'h1;
        ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        chk("p4_seed", state2, 4'h1);
        en2 = 1'b1;
        shifts = 0; zero_seen = 1'b0; prev = state2; c = 0;
        do begin
            tick();
            c++;
            if (state2 != prev) shifts++;
            if (state2 == 4'h0) zero_seen = 1'b1;
            prev = state2;
        end while (!((state2 == 4'h1) && (shifts > 0)) && c < 100);
        en2 = 1'b0;
        chk("p4_period", shifts, 15);
        chk("p4_never_zero", zero_seen, 0);
        chk("p4_lockup", lock2, 0);

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
